reg_bank: RTL
=============

Name: reg_bank

Overview:
- Parametrised, multi-entry successor to the CPU's single 8-bit staged register.
- Holds NREGS registers of WIDTH bits (A/X/Y/S-style) with load, increment and decrement operations.
- Each write passes through one staging register, then commits to the array, so commits are cleanly pipelined.
- Two combinational read ports; sits between the 6502 decode/ALU path and the datapath buses.

Parameters:
- WIDTH, 8, bits per register.
- NREGS, 4, number of registers; must be 2 or more. Internal selector width AW = $clog2(NREGS).
- RESET_VAL, 0, value loaded into every register on reset.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request, sampled on the rising edge.
- wr_sel  in  AW  target register index.
- wr_op  in  2  operation code: 0 NOP, 1 LOAD, 2 INC, 3 DEC.
- wr_data  in  WIDTH  operand for LOAD; ignored for other ops.
- rd_sel_a  in  AW  read port A index.
- rd_data_a  out  WIDTH  read port A data (combinational).
- rd_sel_b  in  AW  read port B index.
- rd_data_b  out  WIDTH  read port B data (combinational).
- pending  out  1  stage holds an uncommitted result.
- wrap  out  1  registered; the committing op wrapped around.
- z_flag  out  1  registered; last committed result equals 0.
- n_flag  out  1  registered; MSB of last committed result.

Behaviour:
- Reset (async, rst_n=0):
  - all registers = RESET_VAL; pending = 0; wrap = 0.
  - z_flag = (RESET_VAL == 0); n_flag = RESET_VAL[WIDTH-1].
  - Any staged write is discarded and never commits.
- Stage capture, edge E with wr_en=1 and wr_op != NOP:
  - Operand = stage result if pending=1 and stage index == wr_sel; otherwise array[wr_sel].
  - Result: LOAD = wr_data; INC = operand+1 mod 2^WIDTH; DEC = operand-1 mod 2^WIDTH.
  - Stage latches index, result and a wrap bit (INC from all-ones, DEC from zero). pending=1 after E.
- wr_en=1 with NOP, or wr_en=0: nothing is captured; pending=0 after E unless a new capture occurs.
- Commit at edge E+1 (when pending=1):
  - array[stage index] = stage result.
  - z_flag, n_flag and wrap update from the stage result.
  - wrap is a one-cycle pulse and is 0 after any edge with no commit. z_flag and n_flag hold their value.
- Latency: a request at edge E becomes visible on rd_data at edge E+1 (two edges from presentation).
- Throughput: one op per cycle.
  - Back-to-back ops on the same register chain correctly through the stage operand (INC,INC adds 2).
  - A capture and a commit in the same edge are legal: the old stage commits while the new stage loads.
- Read ports are purely combinational from the array; indices >= NREGS return 0.
- wr_sel >= NREGS: the request is ignored, with no capture and no flag change.
- Reset deasserted mid-cycle: state stays at reset values until the first rising edge after release.

Optional Feature:
- Macro: REG_BANK_FWD_EN.
- Defined: a read port whose index matches the stage index while pending=1 returns the stage result, i.e. write-to-read in one edge.
- Undefined: read ports show only committed array contents. Pre-commit reads return the old value.
- All other behaviour, the flags and the wrap output are identical in both builds.

Decomposition:
- Package reg_bank_pkg:
  - op code constants OP_NOP/OP_LOAD/OP_INC/OP_DEC.
  - the 2-bit op typedef.
  - a function for wrap detection.
- Sub-module reg_bank_alu (combinational): takes operand, op and wr_data; produces result and wrap. Shared with future counter blocks.
- Top holds the array, the stage and the flags.

Test Plan:
- Reset with RESET_VAL=0 -> all rd_data = 0, z_flag=1, n_flag=0, pending=0, wrap=0.
- LOAD r1=0x80 at edge 1 -> pending=1 after edge 1. After edge 2: rd_data_a(r1)=0x80, n_flag=1, z_flag=0. rd_data before edge 2 = 0 without FWD, 0x80 with REG_BANK_FWD_EN.
- LOAD r2=0xFE, then INC r2 and INC r2 on consecutive edges -> committed sequence 0xFE, 0xFF, 0x00. wrap pulses on the 0x00 commit only; z_flag=1 there.
- DEC r0 from 0x00 -> r0=0xFF, wrap=1, n_flag=1. The next idle edge leaves wrap=0 and r0=0xFF.
- LOAD r3=0x55 then assert rst_n=0 before the commit edge -> r3 stays 0, pending=0. No commit occurs after release.
- Interleaved INC r1 / LOAD r2=0x10 / INC r1 with r1=0x05 -> r1=0x07, r2=0x10. Port B reads r2 while port A reads r1 with no interference.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: op codes and wrap helper shared by reg_bank and future counter blocks.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_LOAD = 2'd1,
    OP_INC  = 2'd2,
    OP_DEC  = 2'd3
  } op_t;

  // INC wraps when the operand is all-ones, DEC wraps when it is zero.
  function automatic logic wrap_detect(op_t op, logic all_ones, logic all_zero);
    logic w;
    w = 1'b0;
    case (op)
      OP_INC:  w = all_ones;
      OP_DEC:  w = all_zero;
      default: w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/reg_bank_if.sv
// reg_bank_if: write request, read ports and status of the register bank.
interface reg_bank_if
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
);
  localparam int AW = $clog2(NREGS);

  logic             wr_en;
  logic [AW-1:0]    wr_sel;
  op_t              wr_op;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_sel_a;
  logic [WIDTH-1:0] rd_data_a;
  logic [AW-1:0]    rd_sel_b;
  logic [WIDTH-1:0] rd_data_b;
  logic             pending;
  logic             wrap;
  logic             z_flag;
  logic             n_flag;

  modport master (
    output wr_en, wr_sel, wr_op, wr_data, rd_sel_a, rd_sel_b,
    input  rd_data_a, rd_data_b, pending, wrap, z_flag, n_flag
  );

  modport slave (
    input  wr_en, wr_sel, wr_op, wr_data, rd_sel_a, rd_sel_b,
    output rd_data_a, rd_data_b, pending, wrap, z_flag, n_flag
  );

endinterface

// File: rtl/reg_bank_alu.sv
// reg_bank_alu: combinational LOAD/INC/DEC with wrap detection.
module reg_bank_alu
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] operand,
  input  op_t              op,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] result,
  output logic             wrap
);

  // result select; NOP passes the operand through
  always_comb begin
    result = operand;
    case (op)
      OP_LOAD: result = wr_data;
      OP_INC:  result = operand + {{(WIDTH-1){1'b0}}, 1'b1};
      OP_DEC:  result = operand - {{(WIDTH-1){1'b0}}, 1'b1};
      default: result = operand;
    endcase
    wrap = wrap_detect(op, &operand, ~|operand);
  end

endmodule

// File: rtl/reg_bank.sv
// reg_bank: NREGS x WIDTH register array with a one-deep staging register
// in front of the commit, two combinational read ports and registered flags.
// Optional macro REG_BANK_FWD_EN: read ports forward the pending stage result.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               NREGS     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic         clk,
  input logic         rst_n,
  reg_bank_if.slave   bus
);

  localparam int AW = $clog2(NREGS);

  logic [WIDTH-1:0] arr [NREGS];

  logic             pending;
  logic [AW-1:0]    stage_sel;
  logic [WIDTH-1:0] stage_res;
  logic             stage_wrap;

  logic             wrap;
  logic             z_flag;
  logic             n_flag;

  logic             sel_ok;
  logic             capture;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] alu_res;
  logic             alu_wrap;

  // operand comes from the stage when it still holds an uncommitted result for the same register
  always_comb begin
    sel_ok  = (int'(bus.wr_sel) < NREGS);
    capture = bus.wr_en && (bus.wr_op != OP_NOP) && sel_ok;
    operand = '0;
    if (pending && (stage_sel == bus.wr_sel))
      operand = stage_res;
    else if (sel_ok)
      operand = arr[bus.wr_sel];
  end

  reg_bank_alu #(.WIDTH(WIDTH)) u_alu (
    .operand (operand),
    .op      (bus.wr_op),
    .wr_data (bus.wr_data),
    .result  (alu_res),
    .wrap    (alu_wrap)
  );

  // stage capture, commit of the previous stage and flag update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) arr[i] <= RESET_VAL;
      pending    <= 1'b0;
      stage_sel  <= '0;
      stage_res  <= '0;
      stage_wrap <= 1'b0;
      wrap       <= 1'b0;
      z_flag     <= (RESET_VAL == '0);
      n_flag     <= RESET_VAL[WIDTH-1];
    end else begin
      if (pending) begin
        arr[stage_sel] <= stage_res;
        z_flag         <= (stage_res == '0);
        n_flag         <= stage_res[WIDTH-1];
        wrap           <= stage_wrap;
      end else begin
        wrap <= 1'b0;
      end
      pending <= capture;
      if (capture) begin
        stage_sel  <= bus.wr_sel;
        stage_res  <= alu_res;
        stage_wrap <= alu_wrap;
      end
    end
  end

  function automatic logic [WIDTH-1:0] read_port(logic [AW-1:0] sel);
    logic [WIDTH-1:0] v;
    v = '0;
    if (int'(sel) < NREGS) v = arr[sel];
`ifdef REG_BANK_FWD_EN
    if (pending && (stage_sel == sel)) v = stage_res;
`endif
    return v;
  endfunction

  // combinational read ports
  always_comb begin
    bus.rd_data_a = read_port(bus.rd_sel_a);
    bus.rd_data_b = read_port(bus.rd_sel_b);
    bus.pending   = pending;
    bus.wrap      = wrap;
    bus.z_flag    = z_flag;
    bus.n_flag    = n_flag;
  end

endmodule
